complex_acc_stream: RTL and testbench
=====================================

Name: complex_acc_stream

Overview:
- Sequential accumulator placed directly downstream of the complex multiplier in the VQE solver datapath.
- Consumes a stream of complex products (re, im, ovr) and sums a programmed number of terms, e.g. an amplitude inner product or expectation term.
- Returns one complex sum per job, in the same sign-magnitude fixed-point format (MSB sign, N-1 fractional bits, range (-1,1)).
- Uses valid/ready handshakes on both sides and carries a sticky overflow flag.

Parameters:
N, 24, data width of every real/imag sample and result (sign-magnitude, N-1 fractional bits)
CW, 4, width of the term counter; a job sums 0..2^CW-1 terms

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a new job; sampled only in IDLE
num_terms  input  CW  number of terms for the job, latched with start
in_valid  input  1  product sample valid
in_ready  output  1  block accepts a sample this cycle
in_re  input  N  real part of product
in_im  input  N  imaginary part of product
in_ovr  input  1  overflow flag from the multiplier for this sample
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
sum_re  output  N  accumulated real part, sign-magnitude
sum_im  output  N  accumulated imaginary part, sign-magnitude
ovr  output  1  sticky overflow for the job
busy  output  1  high in ACC or DONE

Behaviour:
- Reset (async, active-high): state=IDLE; in_ready, out_valid, busy, ovr = 0; sum_re, sum_im = 0; accumulators and counter cleared. Reset mid-job discards all partial state; no output is produced.
- Accumulators: one per component, internal two's complement, N+CW bits.
  - Each accepted sample is converted from sign-magnitude: magnitude zero-extended, then negated if the sign bit is set.
  - Negative zero (MSB=1, magnitude 0) contributes 0.
  - The accumulator never wraps.
- FSM IDLE:
  - in_ready=0, out_valid=0.
  - On start: clear both accumulators, clear ovr, load counter=num_terms.
  - If num_terms=0, go to DONE with sums 0; otherwise go to ACC.
- FSM ACC:
  - in_ready=1.
  - A sample is accepted when in_valid & in_ready: add to both accumulators, ovr |= in_ovr, decrement the counter.
  - Idle cycles (in_valid=0) change nothing.
  - On accepting the last term (counter==1), go to DONE. sum_re/sum_im are registered from the final accumulator values, including that last term.
  - Latency: out_valid rises the cycle after the last accept.
- Output conversion (registered on entry to DONE):
  - Two's complement value v is converted to sign-magnitude.
  - If |v| > 2^(N-1)-1, saturate the magnitude to all ones (keep the sign) and set ovr=1.
  - Zero is always output as all zeros (sign 0).
- FSM DONE:
  - out_valid=1, in_ready=0; sum_re, sum_im and ovr are held stable.
  - On out_ready, go to IDLE (out_valid drops the next cycle).
  - Results persist on sum_re/sum_im/ovr until the next start.
- start is ignored in ACC and DONE. in_valid is ignored in IDLE and DONE.
- busy = (state != IDLE).

Test Plan:
- N=24, num_terms=3; in_re = 0x400000, 0x200000, 0xA00000 (0.5, 0.25, -0.25); in_im = 0x100000 ×3 -> out_valid exactly 1 cycle after 3rd accept; sum_re=0x400000, sum_im=0x300000, ovr=0.
- Saturation: num_terms=4, in_re = 0x400000 ×4, in_im = 0xC00000 ×4 -> sum_re=0x7FFFFF, sum_im=0xFFFFFF, ovr=1.
- Zero handling: num_terms=3, in_re = 0x800000, 0x400000, 0xC00000 -> sum_re=0x000000 (not 0x800000), ovr=0. Separately, num_terms=0 -> out_valid next cycle, sums 0, ovr 0.
- Backpressure: in_valid toggled with gaps between 4 samples, then out_ready held low 5 cycles while start pulses -> only 4 accepts counted; outputs stable; start ignored; IDLE reached one cycle after out_ready.
- Reset mid-job: assert rst after 2 of 4 accepts -> all outputs 0 immediately. New job num_terms=2, in_re = 0x100000 ×2 -> sum_re=0x200000, with no residue from the old job.
- in_ovr: num_terms=2, in_ovr=1 on 2nd sample only, values small (0x000010) -> ovr=1 at out_valid, sum_re=0x000020.

Source files
------------

// File: rtl/complex_acc_stream.sv
// Streaming complex accumulator: sums a programmed number of sign-magnitude
// complex products and returns one saturated sign-magnitude sum per job.
module complex_acc_stream #(
  parameter int N  = 24,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_terms,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_re,
  input  logic [N-1:0]  in_im,
  input  logic          in_ovr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  sum_re,
  output logic [N-1:0]  sum_im,
  output logic          ovr,
  output logic          busy
);

  localparam int AW = N + CW;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic signed [AW-1:0] acc_re, acc_im;
  logic signed [AW-1:0] nx_re, nx_im;
  logic [CW-1:0]        cnt;
  logic                 accept, last;
  logic [N:0]           cv_re, cv_im;

  function automatic logic signed [AW-1:0] sm2tc(input logic [N-1:0] x);
    logic signed [AW-1:0] m;
    m = '0;
    m[N-2:0] = x[N-2:0];
    return x[N-1] ? -m : m;
  endfunction

  // Returns {saturated, sign-magnitude value}; zero never carries a sign.
  function automatic logic [N:0] tc2sm(input logic signed [AW-1:0] v);
    logic          neg;
    logic [AW-1:0] mag;
    logic          sat;
    neg = v[AW-1];
    mag = neg ? -v : v;
    sat = |mag[AW-1:N-1];
    return {sat, neg, sat ? {(N-1){1'b1}} : mag[N-2:0]};
  endfunction

  assign accept = (state == ACC) && in_valid;
  assign last   = accept && (cnt == CW'(1));
  assign nx_re  = acc_re + sm2tc(in_re);
  assign nx_im  = acc_im + sm2tc(in_im);
  assign cv_re  = tc2sm(nx_re);
  assign cv_im  = tc2sm(nx_im);

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (num_terms == '0) ? DONE : ACC;
      ACC:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re <= '0;
      acc_im <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
      sum_re <= '0;
      sum_im <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= num_terms;
            ovr    <= 1'b0;
            sum_re <= '0;
            sum_im <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            acc_re <= nx_re;
            acc_im <= nx_im;
            cnt    <= cnt - CW'(1);
            ovr    <= ovr | in_ovr;
            if (last) begin
              sum_re <= cv_re[N-1:0];
              sum_im <= cv_im[N-1:0];
              ovr    <= ovr | in_ovr | cv_re[N] | cv_im[N];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_acc_stream.sv
// Bench for complex_acc_stream: directed cases plus random jobs checked
// against an integer-arithmetic reference model.
module tb_complex_acc_stream;

  localparam int N  = 24;
  localparam int CW = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [CW-1:0] num_terms = '0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [N-1:0]  in_re = '0;
  logic [N-1:0]  in_im = '0;
  logic          in_ovr = 0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [N-1:0]  sum_re, sum_im;
  logic          ovr, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] q_re[$];
  logic [N-1:0] q_im[$];
  bit           q_ov[$];

  complex_acc_stream #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re),
    .in_im(in_im), .in_ovr(in_ovr), .out_valid(out_valid),
    .out_ready(out_ready), .sum_re(sum_re), .sum_im(sum_im),
    .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint smval(logic [N-1:0] x);
    longint m;
    m = longint'(x[N-2:0]);
    return x[N-1] ? -m : m;
  endfunction

  task automatic to_sm(input longint s, output logic [N-1:0] r,
                       output bit sat);
    longint m, lim;
    lim = (longint'(1) << (N - 1)) - 1;
    m   = (s < 0) ? -s : s;
    sat = (m > lim);
    if (sat) m = lim;
    r = N'(m);
    if (s < 0) r[N-1] = 1'b1;
  endtask

  task automatic model(output logic [N-1:0] er, output logic [N-1:0] ei,
                       output bit eo);
    longint sr = 0, si = 0;
    bit sa, sb;
    eo = 0;
    foreach (q_re[i]) begin
      sr += smval(q_re[i]);
      si += smval(q_im[i]);
      eo |= q_ov[i];
    end
    to_sm(sr, er, sa);
    to_sm(si, ei, sb);
    eo |= sa | sb;
  endtask

  task automatic push(logic [N-1:0] r, logic [N-1:0] i, bit o);
    q_re.push_back(r);
    q_im.push_back(i);
    q_ov.push_back(o);
  endtask

  task automatic clear_q();
    q_re.delete();
    q_im.delete();
    q_ov.delete();
  endtask

  // Runs one job from the queues; gaps between samples, then holds
  // out_ready low for 'hold' cycles while optionally spamming start/in_valid.
  task automatic run_job(int gapmax, int hold, bit spam);
    logic [N-1:0] er, ei;
    bit eo;
    int nt;
    nt = q_re.size();
    model(er, ei, eo);
    @(negedge clk);
    start = 1;
    num_terms = CW'(nt);
    @(negedge clk);
    start = 0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < nt; k++) begin
      repeat ($urandom_range(0, gapmax)) begin
        in_valid = 0;
        in_re = N'($urandom);
        @(negedge clk);
        check("gap_no_out", out_valid, 0);
      end
      in_valid = 1;
      in_re = q_re[k];
      in_im = q_im[k];
      in_ovr = q_ov[k];
      check("in_ready", in_ready, 1);
      check("no_early_out", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 0;
    in_ovr = 0;
    check("out_valid_latency", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("sum_re", sum_re, er);
    check("sum_im", sum_im, ei);
    check("ovr", ovr, eo);
    for (int h = 0; h < hold; h++) begin
      start = spam;
      num_terms = CW'($urandom_range(1, 15));
      in_valid = spam;
      in_re = N'($urandom);
      in_im = N'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_re", sum_re, er);
      check("hold_im", sum_im, ei);
      check("hold_ovr", ovr, eo);
    end
    start = 0;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("persist_re", sum_re, er);
    check("persist_im", sum_im, ei);
    check("persist_ovr", ovr, eo);
  endtask

  initial begin
    #1;
    check("rst_re", sum_re, 0);
    check("rst_im", sum_im, 0);
    check("rst_ovr", ovr, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 0;

    // basic sum 0.5 + 0.25 - 0.25
    clear_q();
    push(24'h400000, 24'h100000, 0);
    push(24'h200000, 24'h100000, 0);
    push(24'hA00000, 24'h100000, 0);
    run_job(0, 0, 0);
    check("t1_re_const", sum_re, 24'h400000);
    check("t1_im_const", sum_im, 24'h300000);

    // saturation both signs
    clear_q();
    repeat (4) push(24'h400000, 24'hC00000, 0);
    run_job(0, 1, 0);
    check("t2_re_const", sum_re, 24'h7FFFFF);
    check("t2_im_const", sum_im, 24'hFFFFFF);
    check("t2_ovr_const", ovr, 1);

    // negative zero and cancellation
    clear_q();
    push(24'h800000, 24'h800000, 0);
    push(24'h400000, 24'h000000, 0);
    push(24'hC00000, 24'h800000, 0);
    run_job(1, 0, 0);
    check("t3_re_zero", sum_re, 24'h000000);

    // zero-term job
    clear_q();
    run_job(0, 0, 0);
    check("t4_zero_re", sum_re, 0);

    // backpressure with gaps and ignored start/in_valid
    clear_q();
    for (int k = 0; k < 4; k++)
      push(N'($urandom), N'($urandom), 0);
    run_job(3, 5, 1);

    // reset mid-job
    @(negedge clk);
    start = 1;
    num_terms = 4'd4;
    @(negedge clk);
    start = 0;
    in_re = 24'h300000;
    in_im = 24'h300000;
    in_ovr = 1;
    in_valid = 1;
    repeat (2) @(negedge clk);
    in_valid = 0;
    in_ovr = 0;
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_re", sum_re, 0);
    @(negedge clk);
    rst = 0;
    clear_q();
    repeat (2) push(24'h100000, 24'h000000, 0);
    run_job(0, 0, 0);
    check("t5_re_const", sum_re, 24'h200000);
    check("t5_ovr_const", ovr, 0);

    // in_ovr on second sample only
    clear_q();
    push(24'h000010, 24'h000000, 0);
    push(24'h000010, 24'h000000, 1);
    run_job(0, 0, 0);
    check("t6_re_const", sum_re, 24'h000020);
    check("t6_ovr_const", ovr, 1);

    // random jobs
    for (int j = 0; j < 30; j++) begin
      int nt;
      clear_q();
      nt = $urandom_range(0, 15);
      for (int k = 0; k < nt; k++) begin
        logic [N-1:0] r, i;
        r = N'($urandom);
        i = N'($urandom);
        if ($urandom_range(0, 3) == 0) r[N-2:0] = '0;
        push(r, i, $urandom_range(0, 9) == 0);
      end
      run_job(2, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
